hex_digit_queue: RTL



---
 rtl/hex_digit_queue.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hex_digit_queue.sv
// Buffers producer-supplied hex digits in a small FIFO and presents them one
// at a time to the seven-segment decoder, holding each for DWELL cycles.
module hex_digit_queue #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int DWELL  = 50000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        digit,
    output logic                     digit_valid,
    output logic                     digit_tick,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DWELL);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   digit_q, digit_d;
    logic                digit_valid_q, digit_valid_d;
    logic                digit_tick_q, digit_tick_d;
    logic                push;
    logic                pop;

    // in_ready looks only at registered occupancy, so a same-cycle pop never frees a slot early
    assign in_ready = (level_q != LVL_FULL);
    assign push     = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        digit_d       = digit_q;
        digit_valid_d = digit_valid_q;
        digit_tick_d  = 1'b0;
        pop           = 1'b0;

        case (state_q)
            IDLE, HOLD: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    state_d = SHOW;
                    count_d = '0;
                end
            end
            SHOW: begin
                if (count_q == CNT_LAST) begin
                    count_d = '0;
                    if (level_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop) begin
            digit_d       = mem_q[rd_ptr_q];
            digit_valid_d = 1'b1;
            digit_tick_d  = 1'b1;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            count_q       <= '0;
            digit_q       <= '0;
            digit_valid_q <= 1'b0;
            digit_tick_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            count_q       <= count_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            digit_tick_q  <= digit_tick_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = digit_valid_q;
    assign digit_tick  = digit_tick_q;
    assign level       = level_q;

endmodule
